// File: rtl/uhci_txn_scheduler.sv
// uhci_txn_scheduler
// Sequences the host SIE/UTMI datapath on the SIE clock. Generates the frame
// timebase and SOF requests, arbitrates the periodic (P) and async (A)
// requesters onto the single SIE token interface, retries transactions that
// end in an error, and returns a completion status to the requester.
//
// Ports:
//   clk, reset            SIE clock, asynchronous active-low reset
//   run                   scheduler enable (Run/Stop)
//   p_*/a_* inputs        level request plus token fields for each requester
//   p_done/a_done         one-cycle completion pulse
//   p_status/a_status     0 ACK, 1 NAK, 2 STALL, 3 ERR, 4 DEFER (held until next done)
//   Address, Endpoint_address, PID, data_toggle
//                         token fields to the SIE, stable from issue until done
//   frame_no, sof         frame number and one-cycle SOF request
//   info_valid, Token_valid  one-cycle issue strobes
//   sof_done              SOF token sent
//   HS_Ready, nak_o, stall_o, Error_Ready, crc_error, Time_out,
//   data_toggle_error     transaction outcome inputs
module uhci_txn_scheduler #(
    parameter int FRAME_CYCLES = 60000,
    parameter int GUARD_CYCLES = 1500,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        p_req,
    input  logic        a_req,
    input  logic [6:0]  p_addr,
    input  logic [6:0]  a_addr,
    input  logic [3:0]  p_ep,
    input  logic [3:0]  a_ep,
    input  logic [7:0]  p_pid,
    input  logic [7:0]  a_pid,
    input  logic        p_toggle,
    input  logic        a_toggle,
    output logic        p_done,
    output logic        a_done,
    output logic [2:0]  p_status,
    output logic [2:0]  a_status,
    output logic [6:0]  Address,
    output logic [3:0]  Endpoint_address,
    output logic [7:0]  PID,
    output logic        data_toggle,
    output logic [10:0] frame_no,
    output logic        sof,
    output logic        info_valid,
    output logic        Token_valid,
    input  logic        sof_done,
    input  logic        HS_Ready,
    input  logic        nak_o,
    input  logic        stall_o,
    input  logic        Error_Ready,
    input  logic        crc_error,
    input  logic        Time_out,
    input  logic        data_toggle_error
);

    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(FRAME_CYCLES - 1);
    // Largest fcnt that still leaves at least GUARD_CYCLES in the frame.
    localparam logic [FW-1:0] GUARD_LAST = FW'(FRAME_CYCLES - 1 - GUARD_CYCLES);

    localparam logic [2:0] ST_ACK   = 3'd0;
    localparam logic [2:0] ST_NAK   = 3'd1;
    localparam logic [2:0] ST_STALL = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_DEFER = 3'd4;

    typedef enum logic [2:0] {IDLE, SOF, SOF_WAIT, ISSUE, WAIT, DONE} state_t;

    state_t         state_reg, state_next;
    logic [FW-1:0]  fcnt_reg;
    logic           sof_pending_reg;
    logic [10:0]    frame_no_reg, frame_no_next;
    logic           gnt_a_reg, gnt_a_next;
    logic [6:0]     addr_reg, addr_next;
    logic [3:0]     ep_reg, ep_next;
    logic [7:0]     pid_reg, pid_next;
    logic           toggle_reg, toggle_next;
    logic [RW-1:0]  retry_reg, retry_next;
    logic [2:0]     p_status_reg, p_status_next;
    logic [2:0]     a_status_reg, a_status_next;
    logic [2:0]     outcome_status;

    logic guard_ok;
    logic any_error;
    logic any_outcome;

    assign guard_ok    = (fcnt_reg <= GUARD_LAST);
    assign any_error   = Error_Ready | crc_error | Time_out | data_toggle_error;
    assign any_outcome = stall_o | nak_o | any_error | HS_Ready;

    // Frame timer. A wrap raises sof_pending; it is cleared when the SOF state
    // is entered (a wrap in the same cycle wins) or whenever run is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_reg        <= '0;
            sof_pending_reg <= 1'b0;
        end else if (!run) begin
            fcnt_reg        <= '0;
            sof_pending_reg <= 1'b0;
        end else begin
            fcnt_reg <= (fcnt_reg == FCNT_LAST) ? '0 : fcnt_reg + 1'b1;
            if (fcnt_reg == FCNT_LAST)
                sof_pending_reg <= 1'b1;
            else if (state_reg == SOF)
                sof_pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            frame_no_reg <= '0;
            gnt_a_reg    <= 1'b0;
            addr_reg     <= '0;
            ep_reg       <= '0;
            pid_reg      <= '0;
            toggle_reg   <= 1'b0;
            retry_reg    <= '0;
            p_status_reg <= '0;
            a_status_reg <= '0;
        end else begin
            state_reg    <= state_next;
            frame_no_reg <= frame_no_next;
            gnt_a_reg    <= gnt_a_next;
            addr_reg     <= addr_next;
            ep_reg       <= ep_next;
            pid_reg      <= pid_next;
            toggle_reg   <= toggle_next;
            retry_reg    <= retry_next;
            p_status_reg <= p_status_next;
            a_status_reg <= a_status_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frame_no_next  = frame_no_reg;
        gnt_a_next     = gnt_a_reg;
        addr_next      = addr_reg;
        ep_next        = ep_reg;
        pid_next       = pid_reg;
        toggle_next    = toggle_reg;
        retry_next     = retry_reg;
        p_status_next  = p_status_reg;
        a_status_next  = a_status_reg;
        outcome_status = ST_ACK;

        case (state_reg)
            IDLE: begin
                if (sof_pending_reg) begin
                    state_next = SOF;
                end else if (run && guard_ok && (p_req || a_req)) begin
                    state_next = ISSUE;
                    retry_next = '0;
                    if (p_req) begin
                        gnt_a_next  = 1'b0;
                        addr_next   = p_addr;
                        ep_next     = p_ep;
                        pid_next    = p_pid;
                        toggle_next = p_toggle;
                    end else begin
                        gnt_a_next  = 1'b1;
                        addr_next   = a_addr;
                        ep_next     = a_ep;
                        pid_next    = a_pid;
                        toggle_next = a_toggle;
                    end
                end
            end
            SOF: begin
                frame_no_next = frame_no_reg + 11'd1;
                state_next    = SOF_WAIT;
            end
            SOF_WAIT: begin
                if (sof_done)
                    state_next = IDLE;
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (any_outcome) begin
                    state_next = DONE;
                    if (stall_o)
                        outcome_status = ST_STALL;
                    else if (nak_o)
                        outcome_status = ST_NAK;
                    else if (any_error) begin
                        if (retry_reg < RW'(MAX_RETRY)) begin
                            if (guard_ok) begin
                                retry_next = retry_reg + 1'b1;
                                state_next = ISSUE;
                            end else begin
                                outcome_status = ST_DEFER;
                            end
                        end else begin
                            outcome_status = ST_ERR;
                        end
                    end else
                        outcome_status = ST_ACK;

                    // Status lands in the register as DONE is entered so it is
                    // valid together with the done pulse.
                    if (state_next == DONE) begin
                        if (gnt_a_reg)
                            a_status_next = outcome_status;
                        else
                            p_status_next = outcome_status;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sof              = (state_reg == SOF);
    assign info_valid       = (state_reg == ISSUE);
    assign Token_valid      = (state_reg == ISSUE);
    assign p_done           = (state_reg == DONE) && !gnt_a_reg;
    assign a_done           = (state_reg == DONE) &&  gnt_a_reg;
    assign p_status         = p_status_reg;
    assign a_status         = a_status_reg;
    assign Address          = addr_reg;
    assign Endpoint_address = ep_reg;
    assign PID              = pid_reg;
    assign data_toggle      = toggle_reg;
    assign frame_no         = frame_no_reg;

endmodule

// File: tb/tb_uhci_txn_scheduler.sv
module tb_uhci_txn_scheduler;

    localparam int FC = 100;
    localparam int GC = 20;
    localparam int MR = 3;

    // Outcome codes used by the stimulus.
    localparam int O_ACK = 0, O_NAK = 1, O_STALL = 2, O_ERR = 3, O_STALL_TO = 4, O_TO = 5;

    logic        clk = 1'b0;
    logic        reset, run;
    logic        p_req, a_req;
    logic [6:0]  p_addr, a_addr;
    logic [3:0]  p_ep, a_ep;
    logic [7:0]  p_pid, a_pid;
    logic        p_toggle, a_toggle;
    logic        p_done, a_done;
    logic [2:0]  p_status, a_status;
    logic [6:0]  Address;
    logic [3:0]  Endpoint_address;
    logic [7:0]  PID;
    logic        data_toggle;
    logic [10:0] frame_no;
    logic        sof, info_valid, Token_valid;
    logic        sof_done;
    logic        HS_Ready, nak_o, stall_o;
    logic        Error_Ready, crc_error, Time_out, data_toggle_error;

    int n_cmp = 0;
    int n_fail = 0;
    int m_fcnt;
    int sof_cnt = 0;
    int iv_cnt = 0;
    int outq[$];
    int last_attempts;

    always #5 clk = ~clk;

    uhci_txn_scheduler #(.FRAME_CYCLES(FC), .GUARD_CYCLES(GC), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .run(run),
        .p_req(p_req), .a_req(a_req),
        .p_addr(p_addr), .a_addr(a_addr),
        .p_ep(p_ep), .a_ep(a_ep),
        .p_pid(p_pid), .a_pid(a_pid),
        .p_toggle(p_toggle), .a_toggle(a_toggle),
        .p_done(p_done), .a_done(a_done),
        .p_status(p_status), .a_status(a_status),
        .Address(Address), .Endpoint_address(Endpoint_address),
        .PID(PID), .data_toggle(data_toggle),
        .frame_no(frame_no), .sof(sof),
        .info_valid(info_valid), .Token_valid(Token_valid),
        .sof_done(sof_done),
        .HS_Ready(HS_Ready), .nak_o(nak_o), .stall_o(stall_o),
        .Error_Ready(Error_Ready), .crc_error(crc_error),
        .Time_out(Time_out), .data_toggle_error(data_toggle_error)
    );

    // Reference frame position: counts cycles while run is high, wraps at FC.
    always @(posedge clk or negedge reset) begin
        if (!reset)
            m_fcnt <= 0;
        else if (!run)
            m_fcnt <= 0;
        else
            m_fcnt <= (m_fcnt == FC - 1) ? 0 : m_fcnt + 1;
    end

    // Strobe counters (count the cycle that just ended).
    always @(posedge clk) begin
        if (sof)        sof_cnt <= sof_cnt + 1;
        if (info_valid) iv_cnt  <= iv_cnt + 1;
    end

    // SIE side: acknowledge every SOF one cycle after it is requested.
    initial begin
        sof_done = 1'b0;
        forever begin
            @(negedge clk);
            if (sof) begin
                @(negedge clk);
                sof_done = 1'b1;
                @(negedge clk);
                sof_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_outcomes();
        HS_Ready = 0; nak_o = 0; stall_o = 0;
        Error_Ready = 0; crc_error = 0; Time_out = 0; data_toggle_error = 0;
    endtask

    task automatic drive_outcome(input int o);
        int k;
        clear_outcomes();
        case (o)
            O_ACK:      HS_Ready = 1;
            O_NAK:      nak_o = 1;
            O_STALL:    stall_o = 1;
            O_STALL_TO: begin stall_o = 1; Time_out = 1; end
            O_TO:       Time_out = 1;
            default: begin
                k = $urandom_range(0, 3);
                Error_Ready       = (k == 0);
                crc_error         = (k == 1);
                Time_out          = (k == 2);
                data_toggle_error = (k == 3);
                HS_Ready          = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic wait_sof();
        int n = 0;
        while (!sof && n < 3 * FC) begin @(negedge clk); n++; end
        if (!sof) check("sof_timeout", 0, 1);
    endtask

    // Wait for an SOF and return at the first IDLE cycle after it.
    task automatic sync_frame();
        @(negedge clk);
        wait_sof();
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_fields();
        p_addr = 7'($urandom); p_ep = 4'($urandom); p_pid = 8'($urandom); p_toggle = 1'($urandom);
        a_addr = 7'($urandom); a_ep = 4'($urandom); a_pid = 8'($urandom); a_toggle = 1'($urandom);
    endtask

    // Drives outcomes from outq for each issue of the granted transaction and
    // checks the result against the retry / status rules.
    task automatic serve(input bit is_a);
        int attempts = 0;
        bit fin = 0;
        int n, o, rem, exp_status;
        bit retry;
        logic [19:0] exp_tok;
        exp_tok = is_a ? {a_addr, a_ep, a_pid, a_toggle} : {p_addr, p_ep, p_pid, p_toggle};
        while (!fin) begin
            n = 0;
            while (!info_valid && n < 40) begin @(negedge clk); n++; end
            if (!info_valid) begin
                check("issue_timeout", 0, 1);
                return;
            end
            check("token_fields", {12'd0, Address, Endpoint_address, PID, data_toggle}, {12'd0, exp_tok});
            check("token_valid", Token_valid, 1);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            o = (outq.size() > 0) ? outq.pop_front() : O_ACK;
            drive_outcome(o);
            rem = FC - 1 - m_fcnt;
            retry = 0;
            exp_status = 0;
            case (o)
                O_ACK:               exp_status = 0;
                O_NAK:               exp_status = 1;
                O_STALL, O_STALL_TO: exp_status = 2;
                default: begin
                    if (attempts < MR) begin
                        if (rem >= GC) retry = 1;
                        else exp_status = 4;
                    end else exp_status = 3;
                end
            endcase
            attempts++;
            @(negedge clk);
            clear_outcomes();
            if (retry) begin
                check("reissue_latency", info_valid, 1);
            end else begin
                check(is_a ? "a_done" : "p_done", {p_done, a_done}, is_a ? 2'b01 : 2'b10);
                check(is_a ? "a_status" : "p_status", is_a ? a_status : p_status, exp_status);
                $display("txn %s attempts=%0d status=%0d expected=%0d", is_a ? "A" : "P",
                         attempts, is_a ? a_status : p_status, exp_status);
                if (is_a) a_req = 0; else p_req = 0;
                fin = 1;
            end
        end
        last_attempts = attempts;
    endtask

    initial begin
        int n, s0, i0, f0, cnt;
        reset = 0; run = 0; p_req = 0; a_req = 0;
        rand_fields();
        clear_outcomes();
        repeat (3) @(negedge clk);
        check("reset_ctl", {sof, info_valid, Token_valid, p_done, a_done, p_status, a_status}, 0);
        check("reset_tok", {Address, Endpoint_address, PID, data_toggle}, 0);
        check("reset_frame_no", frame_no, 0);

        // Frame timebase.
        reset = 1; run = 1;
        @(negedge clk);
        wait_sof();
        check("sof_latency_fcnt", m_fcnt, 1);
        check("frame_no_during_sof", frame_no, 0);
        @(negedge clk);
        check("frame_no_1", frame_no, 1);
        n = 1;
        while (!sof && n < 3 * FC) begin @(negedge clk); n++; end
        check("sof_period", n, FC);
        @(negedge clk);
        check("frame_no_2", frame_no, 2);
        $display("frames: two SOFs seen, frame_no=%0d", frame_no);

        // Simultaneous P and A, both ACK.
        sync_frame();
        rand_fields();
        i0 = iv_cnt;
        p_req = 1; a_req = 1;
        @(negedge clk);
        check("req_latency", info_valid, 1);
        serve(0);
        serve(1);
        repeat (3) @(negedge clk);
        check("two_issues", iv_cnt - i0, 2);

        // Time_out on every attempt -> MAX_RETRY+1 issues then ERR.
        sync_frame();
        rand_fields();
        i0 = iv_cnt;
        outq = '{O_TO, O_TO, O_TO, O_TO};
        a_req = 1;
        serve(1);
        check("timeout_attempts", last_attempts, MR + 1);
        repeat (2) @(negedge clk);
        check("timeout_issue_count", iv_cnt - i0, MR + 1);

        // NAK is not retried; STALL wins over a simultaneous Time_out.
        rand_fields();
        outq = '{O_NAK, O_ACK};
        p_req = 1;
        serve(0);
        check("nak_attempts", last_attempts, 1);
        rand_fields();
        outq = '{O_STALL_TO};
        a_req = 1;
        serve(1);
        check("stall_over_timeout", a_status, 2);

        // Randomized transactions.
        for (int t = 0; t < 6; t++) begin
            bit is_a;
            sync_frame();
            rand_fields();
            is_a = 1'($urandom_range(0, 1));
            outq.delete();
            cnt = $urandom_range(1, 5);
            for (int k = 0; k < cnt; k++) outq.push_back($urandom_range(0, 5));
            if (is_a) a_req = 1; else p_req = 1;
            serve(is_a);
            outq.delete();
        end

        // Request inside the guard window waits for the next SOF.
        n = 0;
        while (m_fcnt != FC - 5 && n < 3 * FC) begin @(negedge clk); n++; end
        rand_fields();
        s0 = sof_cnt;
        p_req = 1;
        n = 0;
        while (!info_valid && n < 60) begin @(negedge clk); n++; end
        check("guard_defers_issue", sof_cnt - s0, 1);
        serve(0);

        // Error on a retry with the guard violated -> DEFER.
        n = 0;
        while (m_fcnt != FC - GC - 2 && n < 3 * FC) begin @(negedge clk); n++; end
        rand_fields();
        outq = '{O_ERR, O_ERR, O_ERR};
        a_req = 1;
        serve(1);
        check("defer_status", a_status, 4);
        outq.delete();

        // run dropped mid-WAIT: transaction completes, nothing more is started.
        sync_frame();
        rand_fields();
        p_req = 1;
        @(negedge clk);
        check("run_drop_issue", info_valid, 1);
        @(negedge clk);
        run = 0;
        a_req = 1;
        @(negedge clk);
        drive_outcome(O_ACK);
        @(negedge clk);
        clear_outcomes();
        check("run_drop_done", {p_done, a_done}, 2'b10);
        check("run_drop_status", p_status, 0);
        p_req = 0;
        s0 = sof_cnt; i0 = iv_cnt; f0 = frame_no;
        repeat (2 * FC) @(negedge clk);
        check("run_off_no_sof", sof_cnt - s0, 0);
        check("run_off_no_grant", iv_cnt - i0, 0);
        check("run_off_frame_no", frame_no, f0);
        a_req = 0;

        // Reset asserted while waiting for an outcome.
        run = 1;
        sync_frame();
        rand_fields();
        p_req = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        check("async_reset_ctl", {sof, info_valid, Token_valid, p_done, a_done, p_status, a_status}, 0);
        check("async_reset_tok", {Address, Endpoint_address, PID, data_toggle}, 0);
        check("async_reset_frame_no", frame_no, 0);
        p_req = 0;
        cnt = 0;
        repeat (3) begin @(negedge clk); cnt += int'(p_done) + int'(a_done); end
        check("no_done_in_reset", cnt, 0);
        reset = 1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
